// File: rtl/mux_rr_nx1.sv
// N-channel registered round-robin multiplexer with valid/ready handshake.
// Optional packet lock (in_last-delimited) enabled by defining MUX_RR_PACKET_LOCK_EN.
module mux_rr_nx1 #(
  parameter  int N     = 4,
  parameter  int WIDTH = 8,
  localparam int SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  input  logic [N-1:0]         in_last,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  output logic [SELW-1:0]      out_sel,
  input  logic                 out_ready
);

  localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

  logic             w_load;
  logic             w_any;
  logic [N-1:0]     w_req;
  logic [N-1:0]     w_grant;
  logic [SELW-1:0]  w_idx;
  logic [SELW-1:0]  w_next_ptr;

  logic [SELW-1:0]  r_ptr;
  logic [SELW-1:0]  r_out_sel;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;

  // The output register may take a new beat when empty or being drained this cycle.
  assign w_load = !r_out_valid || out_ready;

`ifdef MUX_RR_PACKET_LOCK_EN
  logic             r_locked;
  logic [SELW-1:0]  r_lock_ch;

  // While a packet is open only its owner is eligible, even if it is idle.
  assign w_req = r_locked ? (in_valid & (ONE_HOT0 << r_lock_ch)) : in_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_locked  <= 1'b0;
      r_lock_ch <= '0;
    end else if (w_load && w_any) begin
      r_locked  <= !in_last[w_idx];
      r_lock_ch <= w_idx;
    end
  end
`else
  assign w_req = in_valid;
  wire w_unused_last = ^in_last;
`endif

  always_comb begin
    int c;
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    w_any   = 1'b0;
    w_idx   = '0;
    c       = 0;
    for (int off = 0; off < N; off++) begin
      c = int'(r_ptr) + off;
      if (c >= N) c = c - N;
      if (!w_any && w_req[c]) begin
        w_any = 1'b1;
        w_idx = SELW'(c);
      end
    end
    w_grant = w_any ? (ONE_HOT0 << w_idx) : '0;
  end

  assign w_next_ptr = (w_idx == SELW'(N - 1)) ? '0 : w_idx + SELW'(1);
  assign in_ready   = (rst || !w_load) ? '0 : w_grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state is updated with <= so all registers see pre-edge values.
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_ptr       <= '0;
    end else if (w_load) begin
      if (w_any) begin
        r_out_valid <= 1'b1;
        r_out_data  <= in_data[w_idx*WIDTH +: WIDTH];
        r_out_sel   <= w_idx;
        r_ptr       <= w_next_ptr;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_mux_rr_nx1.sv
// Self-checking bench for mux_rr_nx1: behavioural model compared every cycle plus
// directed literal expectations; follows MUX_RR_PACKET_LOCK_EN when defined.
module tb_mux_rr_nx1;

  localparam int NP = 4;
  localparam int WP = 8;
  localparam int SW = $clog2(NP);
`ifdef MUX_RR_PACKET_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic [NP*WP-1:0]   in_data;
  logic [NP-1:0]      in_valid;
  logic [NP-1:0]      in_last;
  logic [NP-1:0]      in_ready;
  logic [WP-1:0]      out_data;
  logic               out_valid;
  logic [SW-1:0]      out_sel;
  logic               out_ready;

  int checks = 0;
  int errors = 0;

  mux_rr_nx1 #(.N(NP), .WIDTH(WP)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the output register contents, the round-robin start point
  // and the open-packet owner.
  bit           m_en = 1'b0;
  bit           m_valid;
  logic [WP-1:0] m_data;
  int           m_sel;
  int           m_ptr;
  bit           m_locked;
  int           m_lock_ch;

  function automatic int m_grant();
    if (m_locked) return in_valid[m_lock_ch] ? m_lock_ch : -1;
    for (int off = 0; off < NP; off++)
      if (in_valid[(m_ptr + off) % NP]) return (m_ptr + off) % NP;
    return -1;
  endfunction

  function automatic logic [NP-1:0] m_ready();
    logic [NP-1:0] r;
    int g;
    r = '0;
    g = m_grant();
    if (!rst && (!m_valid || out_ready) && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 0; m_data = '0; m_sel = 0; m_ptr = 0; m_locked = 0; m_lock_ch = 0;
    end else if (!m_valid || out_ready) begin
      int g;
      g = m_grant();
      if (g >= 0) begin
        m_valid = 1;
        m_data  = in_data[g*WP +: WP];
        m_sel   = g;
        m_ptr   = (g + 1) % NP;
`ifdef MUX_RR_PACKET_LOCK_EN
        m_locked  = !in_last[g];
        m_lock_ch = g;
`endif
      end else begin
        m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_en) begin
      check("model_out_valid", out_valid, m_valid);
      check("model_out_data", out_data, m_data);
      check("model_out_sel", out_sel, m_sel);
      check("model_in_ready", in_ready, m_ready());
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_data(input int ch, input logic [WP-1:0] v);
    in_data[ch*WP +: WP] = v;
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b1; in_valid = 4'hF; in_last = 4'hF;
    for (int i = 0; i < NP; i++) set_data(i, 8'hA0 + 8'(i));
    tick(); tick();
    m_en = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 4'b0000);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_out_sel", out_sel, 0);
    rst = 1'b0;

    // Rotation: A0,A1,A2,A3,A0 back-to-back.
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rot_data", out_data, 8'hA0 + 8'(i % 4));
      check("rot_sel", out_sel, i % 4);
      check("rot_valid", out_valid, 1'b1);
    end

    // Backpressure: hold for 3 cycles, then drain and reload together.
    out_ready = 1'b0; #1;
    check("bp_in_ready", in_ready, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_data", out_data, 8'hA0);
      check("bp_sel", out_sel, 0);
      check("bp_stall_ready", in_ready, 4'b0000);
    end
    out_ready = 1'b1; #1;
    check("bp_release_ready", in_ready, 4'b0010);
    tick();
    check("bp_next_data", out_data, 8'hA1);

    // Sparse and wrap: ptr=2 with ch3,ch1 valid, then ch2 alone from ptr=3.
    in_valid = 4'b1010; #1;
    check("sp_ready3", in_ready, 4'b1000);
    tick();
    check("sp_sel3", out_sel, 3);
    check("sp_ready1", in_ready, 4'b0010);
    tick();
    check("sp_sel1", out_sel, 1);
    in_valid = 4'b0100;
    tick();
    check("sp_sel2a", out_sel, 2);
    check("sp_wrap_ready", in_ready, 4'b0100);
    tick();
    check("sp_sel2b", out_sel, 2);

    // Idle drain of a single beat.
    set_data(2, 8'h5C);
    tick();
    check("idle_data", out_data, 8'h5C);
    check("idle_valid1", out_valid, 1'b1);
    in_valid = 4'b0000;
    tick();
    check("idle_valid0", out_valid, 1'b0);
    check("idle_hold", out_data, 8'h5C);

    // Packet: ch1 beat 1, two-cycle gap with ch0 valid, then beats 2 and 3.
    set_data(0, 8'hC0); set_data(1, 8'hB1);
    in_last = 4'b0000; in_valid = 4'b0010;
    tick();
    check("pk_beat1", out_data, 8'hB1);
    in_valid = 4'b0001; #1;
    check("pk_gap1_ready", in_ready, LOCK ? 4'b0000 : 4'b0001);
    tick();
    check("pk_gap2_ready", in_ready, LOCK ? 4'b0000 : 4'b0001);
    tick();
    in_valid = 4'b0011; #1;
    check("pk_beat2_ready", in_ready, 4'b0010);
    tick();
    in_last = 4'b0010; #1;
    check("pk_beat3_ready", in_ready, LOCK ? 4'b0010 : 4'b0001);
    tick();
    check("pk_after_sel", out_sel, LOCK ? 1 : 0);
    check("pk_after_ready", in_ready, LOCK ? 4'b0001 : 4'b0010);
    in_valid = 4'b0000; in_last = 4'hF;
    tick(); tick();

    // Reset mid-stream drops the pending beat and restarts at ch0.
    in_valid = 4'hF; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b1; #1;
    check("mrst_valid", out_valid, 1'b0);
    check("mrst_data", out_data, 8'h00);
    check("mrst_ready", in_ready, 4'b0000);
    tick();
    rst = 1'b0; out_ready = 1'b1;
    tick();
    check("mrst_first_sel", out_sel, 0);
    check("mrst_first_data", out_data, 8'hC0);
    tick();
    check("mrst_second_sel", out_sel, 1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
